// File: rtl/power_decode_pkg.sv
// Shared PowerISA decode constants: primary opcode, MD/MDS op codes, XO values
// and instruction field positions (LSB-0 positions of the IBM-numbered fields).
package power_decode_pkg;

    localparam logic [5:0] MD_OPCODE = 6'd30;

    typedef enum logic [2:0] {
        OP_RLDICL = 3'd0,
        OP_RLDICR = 3'd1,
        OP_RLDIC  = 3'd2,
        OP_RLDIMI = 3'd3,
        OP_RLDCL  = 3'd4,
        OP_RLDCR  = 3'd5,
        OP_NONE   = 3'd7
    } md_op_e;

    // MD forms use a 3-bit XO; MDS forms extend it by instr[30] to 4 bits.
    localparam logic [2:0] XO3_RLDICL = 3'd0;
    localparam logic [2:0] XO3_RLDICR = 3'd1;
    localparam logic [2:0] XO3_RLDIC  = 3'd2;
    localparam logic [2:0] XO3_RLDIMI = 3'd3;
    localparam logic [3:0] XO4_RLDCL  = 4'd8;
    localparam logic [3:0] XO4_RLDCR  = 4'd9;

    // IBM bit i of a 32-bit word sits at LSB-0 position 31-i.
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RA_LSB     = 16;
    localparam int RB_LSB     = 11;
    localparam int MB_LSB     = 6;
    localparam int MB_HI_BIT  = 5;
    localparam int XO3_LSB    = 2;
    localparam int XO4_LSB    = 1;
    localparam int SH_HI_BIT  = 1;
    localparam int RC_BIT     = 0;

    function automatic logic is_md_xo3(input logic [2:0] xo3);
        return (xo3 == XO3_RLDICL) || (xo3 == XO3_RLDICR) ||
               (xo3 == XO3_RLDIC)  || (xo3 == XO3_RLDIMI);
    endfunction

endpackage

// File: rtl/md_lane_decode.sv
// One-lane MD/MDS decoder: purely combinational, one instruction in and one
// lane of extracted fields out; lanes not owned by this format decode to zero.
module md_lane_decode
    import power_decode_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 5,
    parameter int SHMB_WIDTH  = 6,
    parameter int OP_WIDTH    = 3
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   lane_valid,
    output logic                   valid,
    output logic                   illegal,
    output logic [OP_WIDTH-1:0]    op,
    output logic [REG_WIDTH-1:0]   rs,
    output logic [REG_WIDTH-1:0]   ra,
    output logic [REG_WIDTH-1:0]   rb,
    output logic [SHMB_WIDTH-1:0]  sh,
    output logic [SHMB_WIDTH-1:0]  mbe,
    output logic                   rc
);

    logic [5:0] opcode;
    logic [2:0] xo3;
    logic [3:0] xo4;
    logic       owned;

    assign opcode = instr[OPCODE_LSB +: 6];
    assign xo3    = instr[XO3_LSB +: 3];
    assign xo4    = instr[XO4_LSB +: 4];
    assign owned  = lane_valid && (opcode == MD_OPCODE);

    // MD ops carry a split shift amount in place of RB; MDS ops carry RB and no shift.
    always_comb begin
        valid   = 1'b0;
        illegal = 1'b0;
        op      = OP_WIDTH'(OP_NONE);
        rs      = '0;
        ra      = '0;
        rb      = '0;
        sh      = '0;
        mbe     = '0;
        rc      = 1'b0;
        if (owned) begin
            if (is_md_xo3(xo3) || (xo4 == XO4_RLDCL) || (xo4 == XO4_RLDCR)) begin
                valid = 1'b1;
                rs    = instr[RS_LSB +: REG_WIDTH];
                ra    = instr[RA_LSB +: REG_WIDTH];
                mbe   = {instr[MB_HI_BIT], instr[MB_LSB +: SHMB_WIDTH-1]};
                rc    = instr[RC_BIT];
                if (is_md_xo3(xo3)) begin
                    op = OP_WIDTH'(xo3);
                    sh = {instr[SH_HI_BIT], instr[RB_LSB +: SHMB_WIDTH-1]};
                end else begin
                    op = (xo4 == XO4_RLDCL) ? OP_WIDTH'(OP_RLDCL) : OP_WIDTH'(OP_RLDCR);
                    rb = instr[RB_LSB +: REG_WIDTH];
                end
            end else begin
                illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_format_decoder_pipe.sv
// Multi-lane pipelined MD/MDS decoder: per-lane combinational decode into a
// main output register backed by a skid register, plus saturating statistics.
module md_format_decoder_pipe
    import power_decode_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 5,
    parameter int SHMB_WIDTH  = 6,
    parameter int OP_WIDTH    = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [LANES*INSTR_WIDTH-1:0]  instr_i,
    input  logic [LANES-1:0]              lane_valid_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [LANES-1:0]              lane_valid_o,
    output logic [LANES-1:0]              illegal_o,
    output logic [LANES*OP_WIDTH-1:0]     op_o,
    output logic [LANES*REG_WIDTH-1:0]    rs_o,
    output logic [LANES*REG_WIDTH-1:0]    ra_o,
    output logic [LANES*REG_WIDTH-1:0]    rb_o,
    output logic [LANES*SHMB_WIDTH-1:0]   sh_o,
    output logic [LANES*SHMB_WIDTH-1:0]   mbe_o,
    output logic [LANES-1:0]              rc_o,
    output logic [CNT_WIDTH-1:0]          decoded_cnt_o,
    output logic [CNT_WIDTH-1:0]          illegal_cnt_o
);

    localparam int LW = 2 + OP_WIDTH + 3*REG_WIDTH + 2*SHMB_WIDTH + 1;
    localparam int BW = LANES * LW;
    localparam int PW = $clog2(LANES + 1);

    logic [BW-1:0] dec_bundle;
    logic [BW-1:0] main_data;
    logic [BW-1:0] skid_data;
    logic          main_valid;
    logic          skid_valid;
    logic          accept;
    logic          drain;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic                  l_valid;
        logic                  l_illegal;
        logic [OP_WIDTH-1:0]   l_op;
        logic [REG_WIDTH-1:0]  l_rs;
        logic [REG_WIDTH-1:0]  l_ra;
        logic [REG_WIDTH-1:0]  l_rb;
        logic [SHMB_WIDTH-1:0] l_sh;
        logic [SHMB_WIDTH-1:0] l_mbe;
        logic                  l_rc;

        md_lane_decode #(
            .INSTR_WIDTH (INSTR_WIDTH),
            .REG_WIDTH   (REG_WIDTH),
            .SHMB_WIDTH  (SHMB_WIDTH),
            .OP_WIDTH    (OP_WIDTH)
        ) u_dec (
            .instr      (instr_i[k*INSTR_WIDTH +: INSTR_WIDTH]),
            .lane_valid (lane_valid_i[k]),
            .valid      (l_valid),
            .illegal    (l_illegal),
            .op         (l_op),
            .rs         (l_rs),
            .ra         (l_ra),
            .rb         (l_rb),
            .sh         (l_sh),
            .mbe        (l_mbe),
            .rc         (l_rc)
        );

        assign dec_bundle[k*LW +: LW] = {l_valid, l_illegal, l_op, l_rs, l_ra,
                                         l_rb, l_sh, l_mbe, l_rc};

        assign {lane_valid_o[k], illegal_o[k],
                op_o[k*OP_WIDTH +: OP_WIDTH],
                rs_o[k*REG_WIDTH +: REG_WIDTH],
                ra_o[k*REG_WIDTH +: REG_WIDTH],
                rb_o[k*REG_WIDTH +: REG_WIDTH],
                sh_o[k*SHMB_WIDTH +: SHMB_WIDTH],
                mbe_o[k*SHMB_WIDTH +: SHMB_WIDTH],
                rc_o[k]} = main_data[k*LW +: LW];
    end

    // Ready depends only on skid occupancy, so it comes straight from a flop.
    assign in_ready_o  = ~skid_valid;
    assign out_valid_o = main_valid;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = main_valid & out_ready_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (drain) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data <= dec_bundle;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_data  <= dec_bundle;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= dec_bundle;
                main_valid <= 1'b1;
            end
        end
    end

    logic [PW-1:0]        legal_pop;
    logic [PW-1:0]        illegal_pop;
    logic [CNT_WIDTH:0]   dec_sum;
    logic [CNT_WIDTH:0]   ill_sum;

    always_comb begin
        legal_pop   = '0;
        illegal_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            legal_pop   = legal_pop + PW'(lane_valid_o[k]);
            illegal_pop = illegal_pop + PW'(illegal_o[k]);
        end
    end

    // One extra sum bit detects overflow so the counters clamp instead of wrapping.
    assign dec_sum = {1'b0, decoded_cnt_o} + (CNT_WIDTH+1)'(legal_pop);
    assign ill_sum = {1'b0, illegal_cnt_o} + (CNT_WIDTH+1)'(illegal_pop);

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            decoded_cnt_o <= '0;
            illegal_cnt_o <= '0;
        end else if (drain) begin
            decoded_cnt_o <= dec_sum[CNT_WIDTH] ? '1 : dec_sum[CNT_WIDTH-1:0];
            illegal_cnt_o <= ill_sum[CNT_WIDTH] ? '1 : ill_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_md_format_decoder_pipe.sv
// Scoreboard bench for md_format_decoder_pipe: an IBM-bit-order reference model
// fills a queue on every accepted bundle, drained on every output handshake.
module tb_md_format_decoder_pipe;

    localparam int LANES = 2;

    typedef struct packed {
        logic [1:0]  lv;
        logic [1:0]  il;
        logic [5:0]  op;
        logic [9:0]  rs;
        logic [9:0]  ra;
        logic [9:0]  rb;
        logic [11:0] sh;
        logic [11:0] mbe;
        logic [1:0]  rc;
    } bundle_t;

    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [63:0] instr_i = '0;
    logic [1:0]  lane_valid_i = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [1:0]  lane_valid_o;
    logic [1:0]  illegal_o;
    logic [5:0]  op_o;
    logic [9:0]  rs_o;
    logic [9:0]  ra_o;
    logic [9:0]  rb_o;
    logic [11:0] sh_o;
    logic [11:0] mbe_o;
    logic [1:0]  rc_o;
    logic [15:0] decoded_cnt_o;
    logic [15:0] illegal_cnt_o;

    md_format_decoder_pipe #(
        .LANES(2), .INSTR_WIDTH(32), .REG_WIDTH(5),
        .SHMB_WIDTH(6), .OP_WIDTH(3), .CNT_WIDTH(16)
    ) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .lane_valid_i(lane_valid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .lane_valid_o(lane_valid_o), .illegal_o(illegal_o), .op_o(op_o),
        .rs_o(rs_o), .ra_o(ra_o), .rb_o(rb_o), .sh_o(sh_o), .mbe_o(mbe_o),
        .rc_o(rc_o), .decoded_cnt_o(decoded_cnt_o), .illegal_cnt_o(illegal_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    bundle_t obs;
    assign obs = {lane_valid_o, illegal_o, op_o, rs_o, ra_o, rb_o, sh_o, mbe_o, rc_o};

    bundle_t sb[$];
    bundle_t exp_out;
    logic    have_exp;
    logic    in_fire;
    logic    out_fire;
    int      vectors = 0;
    int      errors = 0;
    int      exp_dec = 0;
    int      exp_ill = 0;

    function automatic logic [5:0] ibm_f(input logic [31:0] w, input int first, input int last);
        logic [5:0] r;
        r = '0;
        for (int i = first; i <= last; i++) r = {r[4:0], w[31-i]};
        return r;
    endfunction

    function automatic bundle_t model(input logic [63:0] ins, input logic [1:0] lv);
        bundle_t b;
        logic [31:0] w;
        logic [5:0] opc, xo3, xo4, rs, ra, f1620, f2125, b26, b30, b31;
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            w     = ins[k*32 +: 32];
            opc   = ibm_f(w, 0, 5);
            xo3   = ibm_f(w, 27, 29);
            xo4   = ibm_f(w, 27, 30);
            rs    = ibm_f(w, 6, 10);
            ra    = ibm_f(w, 11, 15);
            f1620 = ibm_f(w, 16, 20);
            f2125 = ibm_f(w, 21, 25);
            b26   = ibm_f(w, 26, 26);
            b30   = ibm_f(w, 30, 30);
            b31   = ibm_f(w, 31, 31);
            b.op[k*3 +: 3] = 3'd7;
            if (lv[k] && opc == 6'd30) begin
                if (xo3 < 6'd4 || xo4 == 6'd8 || xo4 == 6'd9) begin
                    b.lv[k] = 1'b1;
                    b.op[k*3 +: 3] = (xo3 < 6'd4) ? xo3[2:0] : ((xo4 == 6'd8) ? 3'd4 : 3'd5);
                    b.rs[k*5 +: 5]  = rs[4:0];
                    b.ra[k*5 +: 5]  = ra[4:0];
                    b.mbe[k*6 +: 6] = {b26[0], f2125[4:0]};
                    b.rc[k]         = b31[0];
                    if (xo3 < 6'd4) b.sh[k*6 +: 6] = {b30[0], f1620[4:0]};
                    else            b.rb[k*5 +: 5] = f1620[4:0];
                end else begin
                    b.il[k] = 1'b1;
                end
            end
        end
        return b;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        r[31:26] = 6'd30;
        r[4:2] = 3'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1: r = rand_legal();
            2: begin r[31:26] = 6'd30; r[4:1] = 4'($urandom_range(8, 9)); end
            3: begin r[31:26] = 6'd30; r[4:1] = 4'($urandom_range(10, 15)); end
            4: r[31:26] = 6'd31;
            default: if (r[31:26] == 6'd30) r[31:26] = 6'd24;
        endcase
        return r;
    endfunction

    // Drive one cycle at the falling edge and record the handshakes the next rising edge will take.
    task automatic step(input logic iv, input logic [63:0] ins, input logic [1:0] lv, input logic ordy);
        @(negedge clock_i);
        in_valid_i   = iv;
        instr_i      = ins;
        lane_valid_i = lv;
        out_ready_i  = ordy;
        #1;
        in_fire  = in_valid_i && in_ready_o && reset_n_i;
        out_fire = out_valid_o && out_ready_i && reset_n_i;
        have_exp = 1'b0;
        if (out_fire && sb.size() > 0) begin
            exp_out  = sb.pop_front();
            have_exp = 1'b1;
            exp_dec  = sat(exp_dec + $countones(exp_out.lv));
            exp_ill  = sat(exp_ill + $countones(exp_out.il));
        end
        if (in_fire) sb.push_back(model(ins, lv));
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        vectors++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b need 0", out_valid_o); end
        vectors++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b need 1", in_ready_o); end
        vectors++; if (obs !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h need 0", obs); end
        vectors++; if (decoded_cnt_o !== 16'd0 || illegal_cnt_o !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_counters: got %0d/%0d need 0/0", decoded_cnt_o, illegal_cnt_o);
        end
        sb.delete();
        exp_dec = 0;
        exp_ill = 0;
        reset_n_i = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b1, {32'hFFFF_FFFF, 32'h7864_07C6}, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1);
            if (i == 0) begin
                vectors++; if (!out_fire) begin errors++; $display("[TB] FAIL basic_latency: got out_valid %b need 1", out_valid_o); end
            end
            if (out_fire) begin
                vectors++;
                if (!have_exp || obs !== exp_out) begin errors++; $display("[TB] FAIL basic_bundle: got %h need %h", obs, exp_out); end
                vectors++;
                if (op_o[2:0] !== 3'd1 || rs_o[4:0] !== 5'd3 || ra_o[4:0] !== 5'd4 || lane_valid_o !== 2'b01) begin
                    errors++; $display("[TB] FAIL basic_fields: got op %0d rs %0d ra %0d lv %b need 1 3 4 01", op_o[2:0], rs_o[4:0], ra_o[4:0], lane_valid_o);
                end
            end
        end
        vectors++; if (decoded_cnt_o !== 16'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d need 1", decoded_cnt_o); end
    endtask

    task automatic test_fields();
        logic [31:0] md_a, mds_a, ill_b, mds_b;
        int n_out;
        md_a  = {6'd30, 5'd9, 5'd10, 5'b00001, 5'b00010, 1'b1, 3'd2, 1'b1, 1'b0};
        mds_a = {6'd30, 5'd1, 5'd2, 5'd7, 5'd3, 1'b0, 4'd9, 1'b1};
        ill_b = {6'd30, 5'd4, 5'd5, 5'd6, 5'd7, 1'b1, 4'd12, 1'b0};
        mds_b = {6'd30, 5'd11, 5'd12, 5'd13, 5'd14, 1'b1, 4'd8, 1'b0};
        n_out = 0;
        step(1'b1, {mds_a, md_a}, 2'b11, 1'b1);
        step(1'b1, {mds_b, ill_b}, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, '0, '0, 1'b1);
            if (out_fire) begin
                vectors++;
                if (!have_exp || obs !== exp_out) begin errors++; $display("[TB] FAIL fields_bundle: got %h need %h", obs, exp_out); end
                if (n_out == 0) begin
                    vectors++;
                    if (sh_o[5:0] !== 6'b100001 || mbe_o[5:0] !== 6'b100010) begin
                        errors++; $display("[TB] FAIL shmb_reassembly: got sh %b mbe %b need 100001 100010", sh_o[5:0], mbe_o[5:0]);
                    end
                    vectors++;
                    if (op_o[5:3] !== 3'd5 || rb_o[9:5] !== 5'd7 || sh_o[11:6] !== 6'd0) begin
                        errors++; $display("[TB] FAIL mds_rldcr: got op %0d rb %0d sh %0d need 5 7 0", op_o[5:3], rb_o[9:5], sh_o[11:6]);
                    end
                end else begin
                    vectors++;
                    if (illegal_o !== 2'b01 || lane_valid_o !== 2'b10 || op_o[2:0] !== 3'd7) begin
                        errors++; $display("[TB] FAIL illegal_xo: got il %b lv %b op %0d need 01 10 7", illegal_o, lane_valid_o, op_o[2:0]);
                    end
                end
                n_out++;
            end
        end
        vectors++; if (n_out != 2) begin errors++; $display("[TB] FAIL fields_count_out: got %0d bundles need 2", n_out); end
        vectors++; if (illegal_cnt_o !== 16'(exp_ill) || exp_ill != 1) begin
            errors++; $display("[TB] FAIL illegal_cnt: got %0d need 1", illegal_cnt_o);
        end
        vectors++; if (decoded_cnt_o !== 16'(exp_dec)) begin errors++; $display("[TB] FAIL fields_dec_cnt: got %0d need %0d", decoded_cnt_o, exp_dec); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c;
        logic pend_c;
        int n_out;
        a = {rand_instr(), rand_legal()};
        b = {rand_instr(), rand_legal()};
        c = {rand_instr(), rand_legal()};
        step(1'b1, a, 2'b11, 1'b0);
        vectors++; if (!in_fire) begin errors++; $display("[TB] FAIL bp_accept_first: got in_ready %b need 1", in_ready_o); end
        step(1'b1, b, 2'b11, 1'b0);
        vectors++; if (!in_fire) begin errors++; $display("[TB] FAIL bp_accept_second: got in_ready %b need 1", in_ready_o); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, c, 2'b11, 1'b0);
            vectors++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b need 0", in_ready_o); end
            vectors++; if (out_valid_o !== 1'b1 || sb.size() == 0 || obs !== sb[0]) begin
                errors++; $display("[TB] FAIL bp_hold: got valid %b data %h need 1 %h", out_valid_o, obs, model(a, 2'b11));
            end
        end
        pend_c = 1'b1;
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            step(pend_c, c, 2'b11, 1'b1);
            if (in_fire) pend_c = 1'b0;
            if (i < 3) begin
                vectors++; if (!out_fire) begin errors++; $display("[TB] FAIL bp_consecutive: got no output on release cycle %0d", i); end
            end
            if (out_fire) begin
                vectors++; n_out++;
                if (!have_exp || obs !== exp_out) begin errors++; $display("[TB] FAIL bp_order: got %h need %h", obs, exp_out); end
            end
        end
        vectors++; if (n_out != 3) begin errors++; $display("[TB] FAIL bp_count: got %0d bundles need 3", n_out); end
    endtask

    task automatic test_foreign();
        logic saw;
        saw = 1'b0;
        step(1'b1, {6'd31, 26'($urandom), 6'd31, 26'($urandom)}, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1);
            if (out_fire) begin
                saw = 1'b1;
                vectors++;
                if (!have_exp || obs !== exp_out || lane_valid_o !== 2'b00 || illegal_o !== 2'b00) begin
                    errors++; $display("[TB] FAIL foreign_bundle: got %h need %h", obs, exp_out);
                end
            end
        end
        vectors++; if (!saw) begin errors++; $display("[TB] FAIL foreign_valid: got no output need one bundle"); end
        vectors++; if (decoded_cnt_o !== 16'(exp_dec) || illegal_cnt_o !== 16'(exp_ill)) begin
            errors++; $display("[TB] FAIL foreign_counters: got %0d/%0d need %0d/%0d", decoded_cnt_o, illegal_cnt_o, exp_dec, exp_ill);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            if (i < 70) step(1'($urandom_range(0, 1)), {rand_instr(), rand_instr()}, 2'($urandom), 1'($urandom_range(0, 3) != 0));
            else        step(1'b0, '0, '0, 1'b1);
            if (out_fire) begin
                vectors++;
                if (!have_exp || obs !== exp_out) begin errors++; $display("[TB] FAIL random_bundle: got %h need %h", obs, exp_out); end
            end
        end
        vectors++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL random_drain: got %0d bundles left need 0", sb.size()); end
        vectors++; if (decoded_cnt_o !== 16'(exp_dec) || illegal_cnt_o !== 16'(exp_ill)) begin
            errors++; $display("[TB] FAIL random_counters: got %0d/%0d need %0d/%0d", decoded_cnt_o, illegal_cnt_o, exp_dec, exp_ill);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, {rand_legal(), rand_legal()}, 2'b11, 1'b0);
        step(1'b1, {rand_legal(), rand_legal()}, 2'b11, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        vectors++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_skid_full: got in_ready %b need 0", in_ready_o); end
        reset_n_i = 1'b0;
        step(1'b0, '0, '0, 1'b1);
        vectors++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_reset_flags: got valid %b ready %b need 0 1", out_valid_o, in_ready_o);
        end
        vectors++; if (decoded_cnt_o !== 16'd0 || illegal_cnt_o !== 16'd0 || obs !== '0) begin
            errors++; $display("[TB] FAIL mid_reset_state: got cnt %0d/%0d data %h need 0", decoded_cnt_o, illegal_cnt_o, obs);
        end
        sb.delete();
        exp_dec = 0;
        exp_ill = 0;
        reset_n_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, '0, 1'b1);
            vectors++; if (out_fire) begin errors++; $display("[TB] FAIL mid_no_partial: got stale bundle %h need none", obs); end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 32775; i++) begin
            if (i < 32770) step(1'b1, {rand_legal(), rand_legal()}, 2'b11, 1'b1);
            else           step(1'b0, '0, '0, 1'b1);
            if (out_fire) begin
                vectors++;
                if (!have_exp || obs !== exp_out) begin errors++; $display("[TB] FAIL sat_bundle: got %h need %h", obs, exp_out); end
            end
        end
        vectors++; if (decoded_cnt_o !== 16'hFFFF || exp_dec != 65535) begin
            errors++; $display("[TB] FAIL sat_decoded: got %h need ffff", decoded_cnt_o);
        end
        vectors++; if (illegal_cnt_o !== 16'(exp_ill)) begin errors++; $display("[TB] FAIL sat_illegal: got %0d need %0d", illegal_cnt_o, exp_ill); end
        step(1'b1, {rand_legal(), rand_legal()}, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        vectors++; if (decoded_cnt_o !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_sticky: got %h need ffff", decoded_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fields();
        test_backpressure();
        test_foreign();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        vectors++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL final_queue: got %0d pending need 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/md_format_decoder_pipe.md
Name: md_format_decoder_pipe

Overview:
Multi-lane, pipelined successor to the single-lane MD/MDS decoder. It decodes up to LANES instructions per cycle from the fetch bundle. It fully extracts the PowerISA 3.0B MD/MDS fields, including split sh/mb reassembly, and emits a numeric op code instead of simulation-only messages. Input and output use valid/ready handshakes, with a 2-entry skid buffer so that ready is registered. Saturating statistics counters feed the perf block.

Parameters:
LANES, 2, instructions decoded per bundle (1..8)
INSTR_WIDTH, 32, instruction width
REG_WIDTH, 5, register specifier width
SHMB_WIDTH, 6, reassembled sh / mb-me width
OP_WIDTH, 3, decoded op code width
CNT_WIDTH, 16, statistics counter width

Ports:
clock_i  in  1  clock; all state on rising edge
reset_n_i  in  1  synchronous active-low reset
in_valid_i  in  1  bundle valid
in_ready_o  out  1  bundle accepted when in_valid_i & in_ready_o (registered)
instr_i  in  LANES*INSTR_WIDTH  lane k at [k*32 +: 32], IBM bit order within lane
lane_valid_i  in  LANES  per-lane occupancy mask
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  consumer accepts when out_valid_o & out_ready_i
lane_valid_o  out  LANES  lane holds a legal MD/MDS instruction
illegal_o  out  LANES  lane has opcode 30 with an unassigned XO
op_o  out  LANES*OP_WIDTH  decoded op per lane
rs_o, ra_o, rb_o  out  LANES*REG_WIDTH  RS=[6:10], RA=[11:15], RB=[16:20]
sh_o  out  LANES*SHMB_WIDTH  {instr[30], instr[16:20]}
mbe_o  out  LANES*SHMB_WIDTH  {instr[26], instr[21:25]}
rc_o  out  LANES  instr[31]
decoded_cnt_o  out  CNT_WIDTH  saturating count of legal lanes delivered
illegal_cnt_o  out  CNT_WIDTH  saturating count of illegal lanes delivered

Behaviour:
- Reset (reset_n_i=0 at an edge): out_valid_o=0, in_ready_o=1, skid buffer empty, all data outputs 0, both counters 0. Reset mid-transfer discards any held bundle; no partial output.
- Lane decode is combinational into the pipeline register; latency is 1 cycle from accept to out_valid_o when the output is free.
- Per lane, when lane_valid_i[k]=1 and instr[0:5]=30:
  - XO3=instr[27:29] values 0, 1, 2, 3 give RLDICL=0, RLDICR=1, RLDIC=2, RLDIMI=3.
  - Otherwise, XO4=instr[27:30] values 8 and 9 give RLDCL=4 and RLDCR=5.
  - XO4 values 10..15 give illegal_o=1, lane_valid_o=0, op=7.
  - MD ops set rb_o=0. MDS ops set sh_o=0.
- When lane_valid_i[k]=0 or the opcode is not 30: lane_valid_o=0, illegal_o=0, op=7 (NONE), and all fields are 0. Other format decoders own these lanes.
- Skid buffer: a main output register plus one skid register.
  - in_ready_o=1 only while the skid register is empty.
  - Accept while the output stalls: the bundle goes to the skid register and in_ready_o drops next cycle.
  - out_ready_i with the skid register full: the skid bundle moves to the output, the skid register empties, and in_ready_o rises next cycle.
  - Accept and drain in the same cycle with skid empty: the new bundle directly replaces the output register.
- Output holds stable while out_valid_o=1 and out_ready_i=0.
- Bundle order is preserved; no bundle is dropped or duplicated.
- Counters update only on an output handshake, adding popcount(lane_valid_o) and popcount(illegal_o). They saturate at 2^CNT_WIDTH-1 with no wrap.

Decomposition:
- Shared package power_decode_pkg:
  - MD_OPCODE=30.
  - Op enum values 0..5 and NONE=7.
  - XO constants.
  - Lane field offsets.
- Natural sub-module: md_lane_decode, purely combinational with one instruction in and one lane of fields out, instantiated LANES times via generate.
- Skid buffer and counters stay in the top module.

Test Plan:
- After reset, LANES=2, out_ready_i=1, send lane0 0x7864_07C6 (rldicr-style: RS=3, RA=4, XO3=1) and lane1 invalid -> next cycle out_valid_o=1, op0=1, rs0=3, ra0=4, lane_valid_o=2'b01, decoded_cnt_o=1 after the handshake.
- sh/mbe reassembly: MD instruction with instr[16:20]=5'b00001, instr[30]=1, instr[21:25]=5'b00010, instr[26]=1 -> sh_o=6'b100001, mbe_o=6'b100010.
- MDS XO4=9 with RB=7 -> op=5, rb_o=7, sh_o=0. XO4=12 -> illegal_o=1, lane_valid_o=0, illegal_cnt_o increments by 1.
- Backpressure: hold out_ready_i=0 and present 3 bundles -> the first two are accepted, in_ready_o=0 on the third, outputs stay stable. Release -> the bundles emerge in order over consecutive cycles.
- Opcode 31 in every lane -> out_valid_o=1 with all lane_valid_o=0 and illegal_o=0, counters unchanged.
- Assert reset_n_i=0 with the skid buffer full -> next cycle out_valid_o=0, in_ready_o=1, counters=0. Preload counters near saturation, then check they stick at 0xFFFF.
